// File: rtl/pc_next_select.sv
// Next-PC generator: holds the fetch PC and picks sequential increment or the
// highest-priority redirect target. Define PC_REL_TARGET_EN for signed PC-relative targets.
module pc_next_select #(
    parameter int ADDR_W   = 12,
    parameter int TGT_W    = 8,
    parameter int NUM_SRC  = 2,
    parameter int RESET_PC = 0,
    parameter int INC      = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic [NUM_SRC-1:0]       redir_valid,
    input  logic [NUM_SRC*TGT_W-1:0] redir_target,
    output logic [ADDR_W-1:0]        pc,
    output logic                     pc_valid,
    output logic                     redir_taken,
    output logic                     pending
);

    if (TGT_W > ADDR_W || TGT_W < 1 || NUM_SRC < 1) begin : g_param_check
        $error("pc_next_select: need 1 <= TGT_W <= ADDR_W and NUM_SRC >= 1");
    end

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pc_valid_q, pc_valid_d;
    logic              taken_q, taken_d;
    logic              pending_q, pending_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

    logic              sel_hit;
    logic [TGT_W-1:0]  sel_tgt;
    logic [ADDR_W-1:0] redir_addr;

    // Scan from the lowest priority upward so source 0 is written last and wins.
    always_comb begin
        sel_hit = 1'b0;
        sel_tgt = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                sel_hit = 1'b1;
                sel_tgt = redir_target[i*TGT_W +: TGT_W];
            end
        end
    end

`ifdef PC_REL_TARGET_EN
    // pc is frozen during a stall, so the captured absolute address is still correct at release.
    assign redir_addr = pc_q + ADDR_W'($signed(sel_tgt));
`else
    assign redir_addr = ADDR_W'(sel_tgt);
`endif

    always_comb begin
        pc_d        = pc_q;
        pc_valid_d  = 1'b1;
        taken_d     = 1'b0;
        pending_d   = pending_q;
        pend_addr_d = pend_addr_q;
        if (stall) begin
            if (sel_hit) begin
                pending_d   = 1'b1;
                pend_addr_d = redir_addr;
            end
        end else if (sel_hit) begin
            pc_d      = redir_addr;
            pending_d = 1'b0;
            taken_d   = 1'b1;
        end else if (pending_q) begin
            pc_d      = pend_addr_q;
            pending_d = 1'b0;
            taken_d   = 1'b1;
        end else begin
            pc_d = pc_q + ADDR_W'(INC);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= ADDR_W'(RESET_PC);
            pc_valid_q  <= 1'b0;
            taken_q     <= 1'b0;
            pending_q   <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            pc_q        <= pc_d;
            pc_valid_q  <= pc_valid_d;
            taken_q     <= taken_d;
            pending_q   <= pending_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign pc          = pc_q;
    assign pc_valid    = pc_valid_q;
    assign redir_taken = taken_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_pc_next_select.sv
// Bench for pc_next_select (ADDR_W=12, TGT_W=8, NUM_SRC=2): cycle vector table,
// reset-abort and wrap sequences; relative-target vectors when PC_REL_TARGET_EN is defined.
module tb_pc_next_select;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [1:0]  redir_valid = '0;
    logic [15:0] redir_target = '0;
    logic [11:0] pc;
    logic        pc_valid;
    logic        redir_taken;
    logic        pending;

    int tests = 0;
    int fails = 0;

    // Packed expectation: {pc, pc_valid, redir_taken, pending}.
    logic [14:0] exp_q[$];

    typedef struct {
        string      name;
        logic       r;
        logic       s;
        logic [1:0] rv;
        logic [7:0] t0;
        logic [7:0] t1;
        logic [11:0] epc;
        logic       ev;
        logic       et;
        logic       ep;
    } vec_t;

    vec_t vecs[$];

    pc_next_select #(
        .ADDR_W(12), .TGT_W(8), .NUM_SRC(2), .RESET_PC(0), .INC(1)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redir_valid(redir_valid), .redir_target(redir_target),
        .pc(pc), .pc_valid(pc_valid), .redir_taken(redir_taken), .pending(pending)
    );

    always #5 clk = ~clk;

    function automatic void add(string n, logic r, logic s, logic [1:0] rv, logic [7:0] t0,
                                logic [7:0] t1, logic [11:0] epc, logic ev, logic et, logic ep);
        vec_t v;
        v.name = n; v.r = r; v.s = s; v.rv = rv; v.t0 = t0; v.t1 = t1;
        v.epc = epc; v.ev = ev; v.et = et; v.ep = ep;
        vecs.push_back(v);
    endfunction

    // Drive one cycle, push its expected outputs, then pop and compare after the edge.
    task automatic step(input string n, input logic r, input logic s, input logic [1:0] rv,
                        input logic [7:0] t0, input logic [7:0] t1, input logic [11:0] epc,
                        input logic ev, input logic et, input logic ep);
        logic [14:0] exp_v;
        logic [14:0] got;
        rst = r;
        stall = s;
        redir_valid = rv;
        redir_target = {t1, t0};
        exp_q.push_back({epc, ev, et, ep});
        @(posedge clk);
        #1;
        got = {pc, pc_valid, redir_taken, pending};
        exp_v = exp_q.pop_front();
        tests++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL %s: got pc=%h valid=%b taken=%b pending=%b, expected pc=%h valid=%b taken=%b pending=%b",
                     n, got[14:3], got[2], got[1], got[0], exp_v[14:3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    initial begin
        logic [11:0] cur;
        int guard;

        add("reset0",        1, 0, 2'b00, 8'h00, 8'h00, 12'h000, 0, 0, 0);
        add("reset_ignores", 1, 1, 2'b01, 8'h55, 8'h00, 12'h000, 0, 0, 0);
        add("first_step",    0, 0, 2'b00, 8'h00, 8'h00, 12'h001, 1, 0, 0);
        add("step2",         0, 0, 2'b00, 8'h00, 8'h00, 12'h002, 1, 0, 0);
`ifdef PC_REL_TARGET_EN
        add("rel_minus1",    0, 0, 2'b01, 8'hFF, 8'h00, 12'h001, 1, 1, 0);
        add("rel_wrap_neg",  0, 0, 2'b01, 8'hFF, 8'h00, 12'h000, 1, 1, 0);
        add("rel_ff_at0",    0, 0, 2'b10, 8'h00, 8'hFF, 12'hFFF, 1, 1, 0);
        add("rel_pos1",      0, 0, 2'b01, 8'h7F, 8'h00, 12'h07E, 1, 1, 0);
        add("rel_pos2",      0, 0, 2'b01, 8'h7F, 8'h00, 12'h0FD, 1, 1, 0);
        add("rel_to100",     0, 0, 2'b01, 8'h03, 8'h00, 12'h100, 1, 1, 0);
        add("rel_fe_at100",  0, 0, 2'b01, 8'hFE, 8'h00, 12'h0FE, 1, 1, 0);
        add("rel_stall_cap", 0, 1, 2'b10, 8'h00, 8'h10, 12'h0FE, 1, 0, 1);
        add("rel_stall_hold",0, 1, 2'b00, 8'h00, 8'h00, 12'h0FE, 1, 0, 1);
        add("rel_release",   0, 0, 2'b00, 8'h00, 8'h00, 12'h10E, 1, 1, 0);
        add("rel_seq",       0, 0, 2'b00, 8'h00, 8'h00, 12'h10F, 1, 0, 0);
`else
        add("step3",         0, 0, 2'b00, 8'h00, 8'h00, 12'h003, 1, 0, 0);
        add("redir_to_10",   0, 0, 2'b01, 8'h10, 8'h00, 12'h010, 1, 1, 0);
        add("redir_a5",      0, 0, 2'b01, 8'hA5, 8'h00, 12'h0A5, 1, 1, 0);
        add("after_a5",      0, 0, 2'b00, 8'hA5, 8'h00, 12'h0A6, 1, 0, 0);
        add("prio_both",     0, 0, 2'b11, 8'h10, 8'h20, 12'h010, 1, 1, 0);
        add("prio_src1",     0, 0, 2'b10, 8'h10, 8'h20, 12'h020, 1, 1, 0);
        add("seq_021",       0, 0, 2'b00, 8'h00, 8'h00, 12'h021, 1, 0, 0);
        add("stall1",        0, 1, 2'b00, 8'h00, 8'h00, 12'h021, 1, 0, 0);
        add("stall2_cap",    0, 1, 2'b10, 8'h00, 8'h33, 12'h021, 1, 0, 1);
        add("stall3_hold",   0, 1, 2'b00, 8'h00, 8'h00, 12'h021, 1, 0, 1);
        add("release_33",    0, 0, 2'b00, 8'h00, 8'h00, 12'h033, 1, 1, 0);
        add("seq_034",       0, 0, 2'b00, 8'h00, 8'h00, 12'h034, 1, 0, 0);
        add("cap_33",        0, 1, 2'b10, 8'h00, 8'h33, 12'h034, 1, 0, 1);
        add("cap_over_55",   0, 1, 2'b01, 8'h55, 8'h00, 12'h034, 1, 0, 1);
        add("cap_hold",      0, 1, 2'b00, 8'h00, 8'h00, 12'h034, 1, 0, 1);
        add("live_beats",    0, 0, 2'b01, 8'h44, 8'h00, 12'h044, 1, 1, 0);
        add("pend_dropped",  0, 0, 2'b00, 8'h00, 8'h00, 12'h045, 1, 0, 0);
        add("cap2_33",       0, 1, 2'b10, 8'h00, 8'h33, 12'h045, 1, 0, 1);
        add("cap2_over_66",  0, 1, 2'b01, 8'h66, 8'h00, 12'h045, 1, 0, 1);
        add("release_66",    0, 0, 2'b00, 8'h00, 8'h00, 12'h066, 1, 1, 0);
`endif

        foreach (vecs[k])
            step(vecs[k].name, vecs[k].r, vecs[k].s, vecs[k].rv, vecs[k].t0, vecs[k].t1,
                 vecs[k].epc, vecs[k].ev, vecs[k].et, vecs[k].ep);

        // Reset while a pending entry is held must drop it.
        cur = pc;
        step("abort_cap",   0, 1, 2'b01, 8'h77, 8'h00, cur, 1, 0, 1);
        step("abort_reset", 1, 0, 2'b00, 8'h00, 8'h00, 12'h000, 0, 0, 0);
        step("abort_after", 0, 0, 2'b00, 8'h00, 8'h00, 12'h001, 1, 0, 0);

        // Random stalls mixed into sequential stepping, then wrap from 0xFFF.
        cur = 12'h001;
        guard = 0;
        while (cur != 12'hFFF && guard < 5000) begin
            if ($urandom_range(0, 15) == 0) begin
                step("rand_stall", 0, 1, 2'b00, 8'h00, 8'h00, cur, 1, 0, 0);
            end else begin
                cur = cur + 12'd1;
                step("seq_walk", 0, 0, 2'b00, 8'h00, 8'h00, cur, 1, 0, 0);
            end
            guard++;
        end
        tests++;
        if (cur != 12'hFFF) begin
            fails++;
            $display("FAIL walk_budget: reached pc=%h, required pc=fff", cur);
        end
        step("wrap", 0, 0, 2'b00, 8'h00, 8'h00, 12'h000, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
